crc32_rx_ctrl: RTL and testbench
================================

Name: crc32_rx_ctrl

Overview:
Receive-side frame sequencer and CRC-32 checker for the 4-bit nibble stream in the 25 MHz domain.
- Detects preamble/SFD, frames the payload and counts nibbles.
- Drives an internal nibble-wide CRC-32 engine (init, enable) and checks the residue at end of frame.
- Reports a single-cycle frame result (CRC pass/fail, length, error flags) to the downstream check logic.

Parameters:
CRC_POLY_REF, 32'hEDB88320, reflected CRC-32 polynomial (normal form 32'h4C11DB7)
CRC_INIT, 32'hFFFFFFFF, CRC register value loaded at SFD
CRC_RESIDUE, 32'hDEBB20E3, expected register value after payload+FCS
MIN_NIBBLES, 128, minimum legal frame length in nibbles (64 bytes incl. FCS)
MAX_NIBBLES, 3036, maximum legal frame length in nibbles (1518 bytes incl. FCS)

Ports:
clk_25Mz  in  1  nibble clock; all logic on its rising edge
rst  in  1  asynchronous reset, active-high
rx_dv  in  1  nibble valid / frame envelope
data_in  in  4  nibble, low nibble of each byte first, bit 0 = first bit on wire
frame_done  out  1  one-cycle pulse: result outputs valid
crc_ok  out  1  CRC register equals CRC_RESIDUE at end of frame
len_nibbles  out  12  nibbles counted after SFD (includes FCS), saturates at 4095
err_short  out  1  len_nibbles < MIN_NIBBLES
err_long  out  1  len_nibbles > MAX_NIBBLES
err_odd  out  1  len_nibbles odd (dribble nibble)
crc_value  out  32  live CRC register
busy  out  1  state is not IDLE
good_cnt  out  16  statistics, see Optional Feature
bad_cnt  out  16  statistics, see Optional Feature

Behaviour:
- Reset values:
  - state = IDLE, crc_value = CRC_INIT.
  - All other outputs = 0.
  - Asserting rst mid-frame aborts the frame with no frame_done pulse.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - rx_dv=1 and data_in=4'h5 -> PREAMBLE.
  - rx_dv=1 with any other nibble -> DROP.
- PREAMBLE:
  - rx_dv=0 -> IDLE.
  - 4'h5 -> stay.
  - 4'hD (SFD) -> DATA; same edge: crc_value <= CRC_INIT, counter <= 0.
  - Any other nibble -> DROP.
- DATA, rx_dv=1:
  - counter += 1, saturating at 4095.
  - crc_value updated with 4 serial steps, bit 0 first. Per bit: fb = crc[0]^d; crc = crc>>1; if fb then crc ^= CRC_POLY_REF.
  - The unit is fully combinational per nibble: one nibble per clock, no stall.
- DATA, rx_dv=0 (end of frame), same edge:
  - Register crc_ok, len_nibbles, err_short, err_long, err_odd from the current counter/CRC.
  - frame_done <= 1, state -> IDLE.
  - frame_done is high for exactly the next cycle. Result outputs hold until the next frame_done.
- DROP: ignore data; rx_dv=0 -> IDLE. No frame_done is issued.
- Back-to-back frames: rx_dv may reassert the cycle after end of frame. IDLE handles it normally, in parallel with the frame_done pulse.
- Length 0: SFD immediately followed by rx_dv=0 gives frame_done with len 0, err_short=1 and crc_ok = (CRC_INIT==CRC_RESIDUE), i.e. 0.
- busy = (state != IDLE).

Optional Feature:
Macro CRC_RX_STATS_EN.
- Defined:
  - good_cnt increments on frame_done with crc_ok=1 and no err_* flag.
  - bad_cnt increments on any other frame_done.
  - Both are 16-bit, saturate at 16'hFFFF, and reset to 0.
- Undefined: good_cnt and bad_cnt are tied to 0 and no counter logic is generated.

Test Plan:
- Reset check: rst pulse mid-DATA -> busy=0, crc_value=32'hFFFFFFFF, no frame_done; the next good frame is checked correctly.
- Known vector (MIN_NIBBLES=0): preamble 7×0x55 bytes + SFD, then ASCII "123456789" + FCS bytes 26 39 F4 CB, nibbles low first.
  - Expected: frame_done 1 cycle, crc_ok=1, len_nibbles=26, err_odd=0.
  - Before the FCS nibbles, crc_value = ~32'hCBF43926.
- Corrupted frame: 64-byte frame with one payload bit flipped -> crc_ok=0, len_nibbles=128, err_short=0; with STATS bad_cnt=1.
- Length limits: 63-byte good-CRC frame -> err_short=1. 1519-byte frame -> err_long=1. Extra dribble nibble -> err_odd=1, crc_ok=0.
- Framing: stream starting 0x3 -> DROP, no frame_done until rx_dv falls. Preamble then rx_dv=0 before SFD -> IDLE, no pulse. Two good frames with a one-cycle rx_dv gap -> two frame_done pulses, both crc_ok=1.

Source files
------------

// File: rtl/crc32_rx_ctrl.sv
// Receive frame sequencer with nibble-wide CRC-32 check for the 25 MHz domain.
// Optional frame statistics counters are enabled with `define CRC_RX_STATS_EN.
module crc32_rx_ctrl #(
  parameter logic [31:0] CRC_POLY_REF = 32'hEDB88320,
  parameter logic [31:0] CRC_INIT     = 32'hFFFFFFFF,
  parameter logic [31:0] CRC_RESIDUE  = 32'hDEBB20E3,
  parameter int unsigned MIN_NIBBLES  = 128,
  parameter int unsigned MAX_NIBBLES  = 3036
) (
  input  logic        clk_25Mz,
  input  logic        rst,
  input  logic        rx_dv,
  input  logic [3:0]  data_in,
  output logic        frame_done,
  output logic        crc_ok,
  output logic [11:0] len_nibbles,
  output logic        err_short,
  output logic        err_long,
  output logic        err_odd,
  output logic [31:0] crc_value,
  output logic        busy,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  localparam logic [11:0] MIN_LEN = 12'(MIN_NIBBLES);
  localparam logic [11:0] MAX_LEN = 12'(MAX_NIBBLES);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t      state, state_nxt;
  logic [11:0] cnt;
  logic [31:0] crc_step;
  logic        sfd_hit, eof_hit;
  logic        res_ok, res_short, res_long, res_odd;

  always_ff @(posedge clk_25Mz or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (rx_dv) state_nxt = (data_in == 4'h5) ? PREAMBLE : DROP;
      PREAMBLE: begin
        if (!rx_dv)                 state_nxt = IDLE;
        else if (data_in == 4'hD)   state_nxt = DATA;
        else if (data_in != 4'h5)   state_nxt = DROP;
      end
      DATA:     if (!rx_dv) state_nxt = IDLE;
      DROP:     if (!rx_dv) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    sfd_hit = (state == PREAMBLE) && rx_dv && (data_in == 4'hD);
    eof_hit = (state == DATA) && !rx_dv;
  end

  // Four serial LFSR steps unrolled into one combinational nibble update, bit 0 first.
  always_comb begin
    crc_step = crc_value;
    for (int unsigned i = 0; i < 4; i++)
      crc_step = (crc_step >> 1) ^ ({32{crc_step[0] ^ data_in[i]}} & CRC_POLY_REF);
  end

  always_comb begin
    res_ok    = (crc_value == CRC_RESIDUE);
    res_short = (cnt < MIN_LEN);
    res_long  = (cnt > MAX_LEN);
    res_odd   = cnt[0];
  end

  always_ff @(posedge clk_25Mz or posedge rst) begin
    if (rst) begin
      crc_value   <= CRC_INIT;
      cnt         <= '0;
      frame_done  <= 1'b0;
      crc_ok      <= 1'b0;
      len_nibbles <= '0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      err_odd     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (sfd_hit) begin
        crc_value <= CRC_INIT;
        cnt       <= '0;
      end else if (state == DATA && rx_dv) begin
        crc_value <= crc_step;
        if (cnt != '1) cnt <= cnt + 12'd1;
      end
      if (eof_hit) begin
        frame_done  <= 1'b1;
        crc_ok      <= res_ok;
        len_nibbles <= cnt;
        err_short   <= res_short;
        err_long    <= res_long;
        err_odd     <= res_odd;
      end
    end
  end

`ifdef CRC_RX_STATS_EN
  always_ff @(posedge clk_25Mz or posedge rst) begin
    if (rst) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (eof_hit) begin
      if (res_ok && !res_short && !res_long && !res_odd) begin
        if (good_cnt != '1) good_cnt <= good_cnt + 16'd1;
      end else begin
        if (bad_cnt != '1) bad_cnt <= bad_cnt + 16'd1;
      end
    end
  end
`else
  assign good_cnt = '0;
  assign bad_cnt  = '0;
`endif

endmodule

// File: tb/tb_crc32_rx_ctrl.sv
// Directed bench for crc32_rx_ctrl: frame-level model plus per-cycle output comparison.
module tb_crc32_rx_ctrl;

  localparam logic [31:0] POLY = 32'hEDB88320;
  localparam logic [31:0] INIT = 32'hFFFFFFFF;
  localparam logic [31:0] RES  = 32'hDEBB20E3;

  logic        clk_25Mz = 1'b0;
  logic        rst = 1'b1;
  logic        rx_dv = 1'b0;
  logic [3:0]  data_in = 4'h0;
  logic        frame_done, crc_ok, err_short, err_long, err_odd, busy;
  logic [11:0] len_nibbles;
  logic [31:0] crc_value;
  logic [15:0] good_cnt, bad_cnt;

  crc32_rx_ctrl dut (
    .clk_25Mz(clk_25Mz), .rst(rst), .rx_dv(rx_dv), .data_in(data_in),
    .frame_done(frame_done), .crc_ok(crc_ok), .len_nibbles(len_nibbles),
    .err_short(err_short), .err_long(err_long), .err_odd(err_odd),
    .crc_value(crc_value), .busy(busy), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  always #20 clk_25Mz = ~clk_25Mz;

  typedef struct {
    int unsigned cyc;
    logic        ok;
    logic [11:0] len;
    logic        es, el, eo;
  } exp_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  logic [3:0]  frm[$];
  exp_t        q[$];
  exp_t        pend;
  exp_t        held = '{0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0};
  int unsigned m_good = 0;
  int unsigned m_bad = 0;
  bit          exp_now;

  always @(posedge clk_25Mz) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // CRC over the first n post-SFD nibbles, straight from the bit-serial definition.
  function automatic logic [31:0] crc_of(input int unsigned n);
    logic [31:0] c = INIT;
    for (int unsigned k = 0; k < n; k++)
      for (int unsigned b = 0; b < 4; b++) begin
        logic fb = c[0] ^ frm[k][b];
        c = c >> 1;
        if (fb) c = c ^ POLY;
      end
    return c;
  endfunction

  function automatic void add_byte(input logic [7:0] b);
    frm.push_back(b[3:0]);
    frm.push_back(b[7:4]);
  endfunction

  function automatic void add_fcs();
    logic [31:0] f = ~crc_of(frm.size());
    for (int unsigned k = 0; k < 4; k++) add_byte(f[8*k +: 8]);
  endfunction

  function automatic void build(input int unsigned nbytes);
    frm.delete();
    for (int unsigned k = 0; k < nbytes; k++) add_byte(8'(k * 7 + 3));
    add_fcs();
  endfunction

  function automatic void model_exp();
    int unsigned n = frm.size();
    pend.ok  = (crc_of(n) == RES);
    pend.len = 12'(n > 4095 ? 4095 : n);
    pend.es  = (pend.len < 12'd128);
    pend.el  = (pend.len > 12'd3036);
    pend.eo  = pend.len[0];
  endfunction

  task automatic drive(input logic dv, input logic [3:0] d);
    @(negedge clk_25Mz);
    rx_dv = dv;
    data_in = d;
  endtask

  task automatic send_frame(input int chk_at, input int unsigned gap);
    repeat (15) drive(1'b1, 4'h5);
    drive(1'b1, 4'hD);
    for (int i = 0; i < frm.size(); i++) begin
      @(negedge clk_25Mz);
      if (i == chk_at) chk("crc_before_fcs", crc_value, 32'h340BC6D9);
      rx_dv = 1'b1;
      data_in = frm[i];
    end
    @(negedge clk_25Mz);
    rx_dv = 1'b0;
    data_in = 4'h0;
    pend.cyc = cyc + 1;
    q.push_back(pend);
    repeat (gap - 1) @(negedge clk_25Mz);
  endtask

  task automatic apply_reset();
    @(negedge clk_25Mz);
    rst = 1'b1;
    rx_dv = 1'b0;
    data_in = 4'h0;
    held = '{0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0};
    m_good = 0;
    m_bad = 0;
    q.delete();
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_crc", crc_value, INIT);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_len", 32'(len_nibbles), 32'd0);
    @(negedge clk_25Mz);
    rst = 1'b0;
  endtask

  always @(negedge clk_25Mz) begin
    if (!rst) begin
      exp_now = (q.size() != 0) && (q[0].cyc == cyc);
      chk("frame_done", 32'(frame_done), 32'(exp_now));
      if (exp_now) begin
        held = q.pop_front();
        if (held.ok && !held.es && !held.el && !held.eo) begin
          if (m_good != 65535) m_good++;
        end else begin
          if (m_bad != 65535) m_bad++;
        end
      end
      chk("crc_ok", 32'(crc_ok), 32'(held.ok));
      chk("len_nibbles", 32'(len_nibbles), 32'(held.len));
      chk("err_short", 32'(err_short), 32'(held.es));
      chk("err_long", 32'(err_long), 32'(held.el));
      chk("err_odd", 32'(err_odd), 32'(held.eo));
`ifdef CRC_RX_STATS_EN
      chk("good_cnt", 32'(good_cnt), m_good);
      chk("bad_cnt", 32'(bad_cnt), m_bad);
`else
      chk("good_cnt", 32'(good_cnt), 32'd0);
      chk("bad_cnt", 32'(bad_cnt), 32'd0);
`endif
    end
  end

  initial begin
    string s = "123456789";

    apply_reset();

    // Reference check vector; literal expectations pin the model itself.
    frm.delete();
    for (int i = 0; i < s.len(); i++) add_byte(8'(s[i]));
    chk("model_check_value", crc_of(18) ^ 32'hFFFFFFFF, 32'hCBF43926);
    add_fcs();
    chk("model_fcs_nib0", 32'(frm[18]), 32'h6);
    chk("model_residue", crc_of(26), RES);
    pend = '{0, 1'b1, 12'd26, 1'b1, 1'b0, 1'b0};
    send_frame(18, 3);

    // Reset in the middle of DATA aborts silently.
    repeat (15) drive(1'b1, 4'h5);
    drive(1'b1, 4'hD);
    repeat (6) drive(1'b1, 4'hA);
    @(negedge clk_25Mz);
    chk("busy_in_data", 32'(busy), 32'd1);
    apply_reset();
    repeat (2) @(negedge clk_25Mz);

    build(60); model_exp(); send_frame(-1, 3);
    chk("model_good64_ok", 32'(pend.ok), 32'd1);

    // Single payload bit flip.
    build(60); frm[10][2] = ~frm[10][2]; model_exp();
    chk("model_corrupt_len", 32'(pend.len), 32'd128);
    send_frame(-1, 3);

    build(59); model_exp(); send_frame(-1, 3);
    build(1515); model_exp(); send_frame(-1, 3);
    build(60); frm.push_back(4'h7); model_exp(); send_frame(-1, 3);

    frm.delete(); model_exp(); send_frame(-1, 3);
    frm.delete(); for (int i = 0; i < 2050; i++) add_byte(8'(i)); model_exp();
    send_frame(-1, 3);

    // Non-preamble start goes to DROP.
    drive(1'b1, 4'h3); drive(1'b1, 4'h5); drive(1'b1, 4'h5); drive(1'b1, 4'hD);
    repeat (4) drive(1'b1, 4'h1);
    @(negedge clk_25Mz);
    chk("busy_in_drop", 32'(busy), 32'd1);
    drive(1'b0, 4'h0);
    repeat (3) @(negedge clk_25Mz);

    repeat (5) drive(1'b1, 4'h5);
    drive(1'b0, 4'h0);
    repeat (3) @(negedge clk_25Mz);
    chk("busy_after_abort", 32'(busy), 32'd0);

    // Back-to-back frames with a single idle cycle between them.
    build(60); model_exp(); send_frame(-1, 1);
    build(61); model_exp(); send_frame(-1, 4);

    repeat (4) @(negedge clk_25Mz);
    chk("pending_results", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
